alu_decode_display: RTL and testbench
=====================================

Name: alu_decode_display

Overview:
- Combined decode/execute/readout slice of the multi-cycle RV32I-subset datapath.
- Latches instruction fields and immediate in the ID state and computes the ALU result and branch decision in the EX state.
- Drives five active-low 7-segment digits showing PC, register x5 and the end-of-run flag.
- Sits between instruction fetch, the register file and the control-signal generator. The main FSM supplies `estado`.

Parameters:
- ST_ID, 4'b0001, `estado` code in which decode outputs are captured.
- ST_EX, 4'b0010, `estado` code in which ALU outputs are captured.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- estado  in  4  main FSM state.
- instrucao  in  32  fetched instruction.
- readdata1R  in  32  rs1 value from the register file.
- readdata2R  in  32  rs2 value from the register file.
- alusrc  in  1  1 = operand B is the immediate.
- alucontrol  in  4  ALU operation select.
- branch  in  1  current instruction is a branch.
- pc_lo  in  8  PC[7:0] for display.
- x5_lo  in  8  x5[7:0] for display.
- final  in  4  end-of-execution flag.
- opcode  out  7  decoded instruction field.
- rd  out  5  decoded instruction field.
- rs1  out  5  decoded instruction field.
- rs2  out  5  decoded instruction field.
- funct3  out  3  decoded instruction field.
- funct7  out  7  decoded instruction field.
- immediate  out  12  raw 12-bit immediate.
- negativo  out  1  immediate sign bit.
- tipo  out  3  instruction class.
- aluresult1  out  1  zero flag.
- aluresult2  out  32  ALU result.
- pcsrc  out  1  branch taken.
- display1..display5  out  7 each  segments {g,f,e,d,c,b,a}, 0 = lit.

Behaviour:
- Reset (rst=0, asynchronous): all registered outputs go to 0, except tipo = 3'b111. Reset is honoured in any state, including mid-EX.
- Decode, on a rising clk edge while estado==ST_ID:
  - field outputs: opcode=instr[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25]
  - tipo by opcode: 0110011→0 (R), 0010011→1 (I-ALU), 0000011→2 (load), 0100011→3 (store), 1100011→4 (branch), other→7
  - immediate for I/load: instr[31:20]
  - immediate for S: {instr[31:25], instr[11:7]}
  - immediate for B: {instr[31], instr[7], instr[30:25], instr[11:8]}, i.e. byte offset >>1
  - immediate for R/other: 0
  - negativo = instr[31] for tipo 1–4, else 0
  - in all other states the decode outputs hold.
- Execute, on a rising clk edge while estado==ST_EX:
  - immext = {20{negativo}, immediate}
  - operand B = readdata2R when branch=1 (alusrc ignored); else immext when alusrc=1; else readdata2R.
  - alucontrol: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 XOR, 0100 SLL by B[4:0], 0101 SRL by B[4:0], 0111 SLT (signed, result 0/1), other → 0.
  - arithmetic is 32-bit wrap-around.
  - aluresult1 = (result == 0).
  - pcsrc = branch & (funct3==001 ? result!=0 : result==0), i.e. BEQ/BNE; funct3 comes from the latched decode output.
  - in all other states aluresult1, aluresult2 and pcsrc hold.
- Display is purely combinational and not affected by reset:
  - display1 = hex(pc_lo[3:0]), display2 = hex(pc_lo[7:4]), display3 = hex(x5_lo[3:0]), display4 = hex(x5_lo[7:4]).
  - display5 = 7'h0E ("F") when final != 0, else 7'h7F (blank).
  - hex map 0–F: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E.

Test Plan:
- rst=0 pulse mid-run → all outputs 0, tipo=7. With pc_lo=0, display1=0x40 and display5=0x7F.
- estado=1, instrucao=0x00500293 (addi x5,x0,5) → opcode=0x13, rd=5, rs1=0, immediate=0x005, tipo=1, negativo=0. Changing instrucao with estado=0 leaves all decode outputs unchanged.
- Decode 0xFFF08093, then estado=2 with readdata1R=10, alusrc=1, alucontrol=0010 → immediate=0xFFF, negativo=1, aluresult2=9, aluresult1=0.
- Decode 0x40208133 (sub) → tipo=0, funct7=0x20. EX with readdata1R=readdata2R=7, alucontrol=0110 → aluresult2=0, aluresult1=1, pcsrc=0 (branch=0).
- Decode 0xFE208CE3 (beq, −8) → tipo=4, immediate=0xFFC, negativo=1. EX with branch=1, alucontrol=0110, alusrc=1:
  - operands 3,3 → pcsrc=1
  - operands 3,4 → pcsrc=0
- pc_lo=0x2C, x5_lo=0x05, final=1 → display1=0x46, display2=0x24, display3=0x12, display4=0x40, display5=0x0E.

Source files
------------

// File: rtl/alu_decode_display.sv
// alu_decode_display
//   Decode / execute / readout slice of the multi-cycle RV32I-subset datapath.
//   - estado == ST_ID : latch the instruction fields, the instruction class and the raw immediate.
//   - estado == ST_EX : latch the ALU result, the zero flag and the branch decision.
//   - display1..5     : combinational active-low 7-segment readout of PC[7:0], x5[7:0] and the end flag.
//
// Ports
//   clk, rst                   clock; asynchronous active-low reset
//   estado [3:0]               main FSM state
//   instrucao [31:0]           fetched instruction
//   readdata1R/2R [31:0]       rs1 / rs2 register values
//   alusrc, alucontrol, branch control-signal generator outputs
//   pc_lo, x5_lo [7:0]         values shown on the displays
//   final_flag [3:0]           end-of-execution flag. "final" is a reserved SystemVerilog keyword,
//                              so the port carries the _flag suffix.
//   opcode..funct7             latched instruction fields
//   immediate, negativo, tipo  latched raw immediate, its sign bit, and the instruction class
//   aluresult1/2, pcsrc        latched zero flag, ALU result, branch taken
//   display1..display5         segments {g,f,e,d,c,b,a}; 0 = lit

module hex7seg (
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h7F;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end
endmodule

module alu_decode_display #(
    parameter logic [3:0] ST_ID = 4'b0001,
    parameter logic [3:0] ST_EX = 4'b0010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  estado,
    input  logic [31:0] instrucao,
    input  logic [31:0] readdata1R,
    input  logic [31:0] readdata2R,
    input  logic        alusrc,
    input  logic [3:0]  alucontrol,
    input  logic        branch,
    input  logic [7:0]  pc_lo,
    input  logic [7:0]  x5_lo,
    input  logic [3:0]  final_flag,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [11:0] immediate,
    output logic        negativo,
    output logic [2:0]  tipo,
    output logic        aluresult1,
    output logic [31:0] aluresult2,
    output logic        pcsrc,
    output logic [6:0]  display1,
    output logic [6:0]  display2,
    output logic [6:0]  display3,
    output logic [6:0]  display4,
    output logic [6:0]  display5
);
    localparam int NUM_DIGITS = 4;

    // ---------------- decode ----------------
    logic [2:0]  tipo_n;
    logic [11:0] imm_n;
    logic        neg_n;

    always_comb begin
        tipo_n = 3'd7;
        case (instrucao[6:0])
            7'b0110011: tipo_n = 3'd0;
            7'b0010011: tipo_n = 3'd1;
            7'b0000011: tipo_n = 3'd2;
            7'b0100011: tipo_n = 3'd3;
            7'b1100011: tipo_n = 3'd4;
            default:    tipo_n = 3'd7;
        endcase

        imm_n = 12'd0;
        neg_n = 1'b0;
        case (tipo_n)
            3'd1, 3'd2: imm_n = instrucao[31:20];
            3'd3:       imm_n = {instrucao[31:25], instrucao[11:7]};
            // branch offset kept in halfword units (byte offset >> 1)
            3'd4:       imm_n = {instrucao[31], instrucao[7], instrucao[30:25], instrucao[11:8]};
            default:    imm_n = 12'd0;
        endcase
        if (tipo_n inside {3'd1, 3'd2, 3'd3, 3'd4})
            neg_n = instrucao[31];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opcode    <= '0;
            rd        <= '0;
            rs1       <= '0;
            rs2       <= '0;
            funct3    <= '0;
            funct7    <= '0;
            immediate <= '0;
            negativo  <= 1'b0;
            tipo      <= 3'b111;
        end else if (estado == ST_ID) begin
            opcode    <= instrucao[6:0];
            rd        <= instrucao[11:7];
            funct3    <= instrucao[14:12];
            rs1       <= instrucao[19:15];
            rs2       <= instrucao[24:20];
            funct7    <= instrucao[31:25];
            immediate <= imm_n;
            negativo  <= neg_n;
            tipo      <= tipo_n;
        end
    end

    // ---------------- execute ----------------
    // Works from the latched immediate/negativo/funct3, so EX must follow an ID capture.
    logic [31:0] immext, opb, res_n;
    logic        zero_n, pcsrc_n;

    assign immext = {{20{negativo}}, immediate};
    // branches always compare two registers, whatever alusrc says
    assign opb    = (branch || !alusrc) ? readdata2R : immext;

    always_comb begin
        res_n = 32'd0;
        case (alucontrol)
            4'b0000: res_n = readdata1R & opb;
            4'b0001: res_n = readdata1R | opb;
            4'b0010: res_n = readdata1R + opb;
            4'b0110: res_n = readdata1R - opb;
            4'b0011: res_n = readdata1R ^ opb;
            4'b0100: res_n = readdata1R << opb[4:0];
            4'b0101: res_n = readdata1R >> opb[4:0];
            4'b0111: res_n = {31'd0, $signed(readdata1R) < $signed(opb)};
            default: res_n = 32'd0;
        endcase
    end

    assign zero_n  = (res_n == 32'd0);
    // BNE (funct3 001) takes on non-zero difference, everything else behaves as BEQ
    assign pcsrc_n = branch & ((funct3 == 3'b001) ? !zero_n : zero_n);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aluresult1 <= 1'b0;
            aluresult2 <= '0;
            pcsrc      <= 1'b0;
        end else if (estado == ST_EX) begin
            aluresult1 <= zero_n;
            aluresult2 <= res_n;
            pcsrc      <= pcsrc_n;
        end
    end

    // ---------------- display ----------------
    logic [NUM_DIGITS-1:0][3:0] nibs;
    logic [NUM_DIGITS-1:0][6:0] segs;

    assign nibs = {x5_lo, pc_lo};   // digit 0 = pc_lo[3:0] ... digit 3 = x5_lo[7:4]

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        hex7seg u_hex (.nib(nibs[i]), .seg(segs[i]));
    end

    assign display1 = segs[0];
    assign display2 = segs[1];
    assign display3 = segs[2];
    assign display4 = segs[3];
    assign display5 = (final_flag != 4'd0) ? 7'h0E : 7'h7F;

endmodule

// File: tb/tb_alu_decode_display.sv
module tb_alu_decode_display;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  estado;
    logic [31:0] instrucao, readdata1R, readdata2R;
    logic        alusrc, branch;
    logic [3:0]  alucontrol, final_flag;
    logic [7:0]  pc_lo, x5_lo;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3, tipo;
    logic [11:0] immediate;
    logic        negativo, aluresult1, pcsrc;
    logic [31:0] aluresult2;
    logic [6:0]  display1, display2, display3, display4, display5;

    int vectors = 0;
    int miscompares = 0;

    alu_decode_display dut (
        .clk(clk), .rst(rst), .estado(estado), .instrucao(instrucao),
        .readdata1R(readdata1R), .readdata2R(readdata2R), .alusrc(alusrc),
        .alucontrol(alucontrol), .branch(branch), .pc_lo(pc_lo), .x5_lo(x5_lo),
        .final_flag(final_flag), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .immediate(immediate), .negativo(negativo),
        .tipo(tipo), .aluresult1(aluresult1), .aluresult2(aluresult2), .pcsrc(pcsrc),
        .display1(display1), .display2(display2), .display3(display3),
        .display4(display4), .display5(display5)
    );

    always #5 clk = ~clk;

    logic [6:0] hexmap [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void dec_model(input logic [31:0] i, output logic [2:0] t,
                                      output logic [11:0] imm, output logic n);
        logic [12:0] boff;
        case (i[6:0])
            7'h33: t = 3'd0;
            7'h13: t = 3'd1;
            7'h03: t = 3'd2;
            7'h23: t = 3'd3;
            7'h63: t = 3'd4;
            default: t = 3'd7;
        endcase
        imm = 12'd0;
        if (t == 3'd1 || t == 3'd2) imm = i[31:20];
        else if (t == 3'd3) imm = {i[31:25], i[11:7]};
        else if (t == 3'd4) begin
            boff = {i[31], i[7], i[30:25], i[11:8], 1'b0};  // true byte offset
            imm  = boff[12:1];
        end
        n = (t >= 3'd1 && t <= 3'd4) ? i[31] : 1'b0;
    endfunction

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] c);
        int sa, sb;
        sa = a; sb = b;
        case (c)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd6: return a - b;
            4'd3: return a ^ b;
            4'd4: return a << (b % 32);
            4'd5: return a >> (b % 32);
            4'd7: return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] opb_model(input logic [31:0] b, input logic src,
                                             input logic br, input logic [11:0] imm,
                                             input logic n);
        int sx;
        if (br || !src) return b;
        sx = n ? (int'(imm) - 4096) : int'(imm);
        return sx;
    endfunction

    // ---------------- drivers ----------------
    task automatic do_decode(input logic [31:0] ins);
        @(negedge clk);
        instrucao = ins; estado = 4'd1;
        @(negedge clk);
        estado = 4'd0;
    endtask

    task automatic do_exec(input logic [31:0] a, input logic [31:0] b, input logic src,
                           input logic [3:0] c, input logic br);
        @(negedge clk);
        readdata1R = a; readdata2R = b; alusrc = src; alucontrol = c; branch = br;
        estado = 4'd2;
        @(negedge clk);
        estado = 4'd0;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a, b;
        logic        src;
        logic [3:0]  ctl;
        logic        br;
        logic [2:0]  e_tipo;
        logic [11:0] e_imm;
        logic        e_neg;
        logic [31:0] e_res;
        logic        e_pc;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [2:0]  mt;
        logic [11:0] mi;
        logic        mn, mpc;
        logic [31:0] mr, ri;
        logic [6:0]  ops [6];

        tbl[0]  = '{32'h00500293, 32'd0,        32'd0,    1'b1, 4'd2, 1'b0, 3'd1, 12'h005, 1'b0, 32'd5,        1'b0};
        tbl[1]  = '{32'hFFF08093, 32'd10,       32'd0,    1'b1, 4'd2, 1'b0, 3'd1, 12'hFFF, 1'b1, 32'd9,        1'b0};
        tbl[2]  = '{32'h40208133, 32'd7,        32'd7,    1'b0, 4'd6, 1'b0, 3'd0, 12'h000, 1'b0, 32'd0,        1'b0};
        tbl[3]  = '{32'hFE208CE3, 32'd3,        32'd3,    1'b1, 4'd6, 1'b1, 3'd4, 12'hFFC, 1'b1, 32'd0,        1'b1};
        tbl[4]  = '{32'hFE208CE3, 32'd3,        32'd4,    1'b1, 4'd6, 1'b1, 3'd4, 12'hFFC, 1'b1, 32'hFFFFFFFF, 1'b0};
        tbl[5]  = '{32'h00112423, 32'h100,      32'd0,    1'b1, 4'd2, 1'b0, 3'd3, 12'h008, 1'b0, 32'h108,      1'b0};
        tbl[6]  = '{32'h00209463, 32'd5,        32'd6,    1'b1, 4'd6, 1'b1, 3'd4, 12'h004, 1'b0, 32'hFFFFFFFF, 1'b1};
        tbl[7]  = '{32'h80012083, 32'h1000,     32'd0,    1'b1, 4'd2, 1'b0, 3'd2, 12'h800, 1'b1, 32'h800,      1'b0};
        tbl[8]  = '{32'h00000033, 32'd1,        32'h23,   1'b0, 4'd4, 1'b0, 3'd0, 12'h000, 1'b0, 32'd8,        1'b0};
        tbl[9]  = '{32'h00000033, 32'hFFFFFFFF, 32'd1,    1'b0, 4'd7, 1'b0, 3'd0, 12'h000, 1'b0, 32'd1,        1'b0};
        tbl[10] = '{32'hFFFFFFFF, 32'd9,        32'd9,    1'b0, 4'hF, 1'b0, 3'd7, 12'h000, 1'b0, 32'd0,        1'b0};
        tbl[11] = '{32'h00000033, 32'h80000000, 32'h1F,   1'b0, 4'd5, 1'b0, 3'd0, 12'h000, 1'b0, 32'd1,        1'b0};

        rst = 1'b0; estado = 4'd0; instrucao = '0; readdata1R = '0; readdata2R = '0;
        alusrc = 1'b0; alucontrol = '0; branch = 1'b0; pc_lo = '0; x5_lo = '0; final_flag = '0;

        // reset state
        #12;
        chk("rst_opcode", {25'd0, opcode}, 32'd0);
        chk("rst_tipo", {29'd0, tipo}, 32'd7);
        chk("rst_imm", {20'd0, immediate}, 32'd0);
        chk("rst_res", aluresult2, 32'd0);
        chk("rst_flags", {29'd0, negativo, aluresult1, pcsrc}, 32'd0);
        chk("rst_disp1", {25'd0, display1}, 32'h40);
        chk("rst_disp5", {25'd0, display5}, 32'h7F);
        @(negedge clk);
        rst = 1'b1;

        // table-driven vectors
        foreach (tbl[k]) begin
            do_decode(tbl[k].instr);
            chk($sformatf("t%0d_tipo", k), {29'd0, tipo}, {29'd0, tbl[k].e_tipo});
            chk($sformatf("t%0d_imm", k), {20'd0, immediate}, {20'd0, tbl[k].e_imm});
            chk($sformatf("t%0d_neg", k), {31'd0, negativo}, {31'd0, tbl[k].e_neg});
            chk($sformatf("t%0d_opcode", k), {25'd0, opcode}, {25'd0, tbl[k].instr[6:0]});
            do_exec(tbl[k].a, tbl[k].b, tbl[k].src, tbl[k].ctl, tbl[k].br);
            chk($sformatf("t%0d_res", k), aluresult2, tbl[k].e_res);
            chk($sformatf("t%0d_zero", k), {31'd0, aluresult1}, {31'd0, tbl[k].e_res == 32'd0});
            chk($sformatf("t%0d_pcsrc", k), {31'd0, pcsrc}, {31'd0, tbl[k].e_pc});
        end

        // sub: funct7 field
        do_decode(32'h40208133);
        chk("sub_funct7", {25'd0, funct7}, 32'h20);

        // decode and EX outputs hold outside their states
        do_decode(32'h00500293);
        do_exec(32'd40, 32'd2, 1'b0, 4'd2, 1'b0);
        @(negedge clk);
        instrucao = 32'hFFFFFFFF; alucontrol = 4'd6; readdata1R = 32'd1; estado = 4'd0;
        @(negedge clk);
        estado = 4'd3;
        @(negedge clk);
        estado = 4'd0;
        chk("hold_opcode", {25'd0, opcode}, 32'h13);
        chk("hold_rd", {27'd0, rd}, 32'd5);
        chk("hold_rs1", {27'd0, rs1}, 32'd0);
        chk("hold_imm", {20'd0, immediate}, 32'h005);
        chk("hold_tipo", {29'd0, tipo}, 32'd1);
        chk("hold_res", aluresult2, 32'd42);

        // asynchronous reset asserted in the middle of an EX cycle
        @(negedge clk);
        readdata1R = 32'd1; readdata2R = 32'd2; alucontrol = 4'd2; alusrc = 1'b0; estado = 4'd2;
        #2 rst = 1'b0;
        #1;
        chk("arst_res", aluresult2, 32'd0);
        chk("arst_tipo", {29'd0, tipo}, 32'd7);
        chk("arst_opcode", {25'd0, opcode}, 32'd0);
        @(negedge clk);
        chk("arst_held_res", aluresult2, 32'd0);
        estado = 4'd0;
        rst = 1'b1;

        // randomized decode+execute against the model
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h00};
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a, b;
            logic        src, br;
            logic [3:0]  c;
            ri = $urandom();
            if ($urandom_range(0, 5) != 5) ri[6:0] = ops[$urandom_range(0, 5)];
            do_decode(ri);
            dec_model(ri, mt, mi, mn);
            chk("rnd_tipo", {29'd0, tipo}, {29'd0, mt});
            chk("rnd_imm", {20'd0, immediate}, {20'd0, mi});
            chk("rnd_neg", {31'd0, negativo}, {31'd0, mn});
            chk("rnd_fields", {opcode, rd, funct3, rs1, rs2, funct7},
                {ri[6:0], ri[11:7], ri[14:12], ri[19:15], ri[24:20], ri[31:25]});
            a = $urandom(); b = $urandom();
            if ($urandom_range(0, 3) == 0) b = a;
            src = 1'($urandom_range(0, 1));
            br  = 1'($urandom_range(0, 1));
            c   = 4'($urandom_range(0, 15));
            do_exec(a, b, src, c, br);
            mr  = alu_model(a, opb_model(b, src, br, mi, mn), c);
            mpc = br && ((ri[14:12] == 3'b001) ? (mr != 0) : (mr == 0));
            chk("rnd_res", aluresult2, mr);
            chk("rnd_zero", {31'd0, aluresult1}, {31'd0, mr == 32'd0});
            chk("rnd_pcsrc", {31'd0, pcsrc}, {31'd0, mpc});
        end

        // display readout
        pc_lo = 8'h2C; x5_lo = 8'h05; final_flag = 4'd1;
        #1;
        chk("disp1", {25'd0, display1}, 32'h46);
        chk("disp2", {25'd0, display2}, 32'h24);
        chk("disp3", {25'd0, display3}, 32'h12);
        chk("disp4", {25'd0, display4}, 32'h40);
        chk("disp5", {25'd0, display5}, 32'h0E);
        for (int n = 0; n < 40; n++) begin
            pc_lo = 8'($urandom()); x5_lo = 8'($urandom()); final_flag = 4'($urandom_range(0, 15));
            #1;
            chk("rnd_disp", {display4, display3, display2, display1},
                {hexmap[x5_lo[7:4]], hexmap[x5_lo[3:0]], hexmap[pc_lo[7:4]], hexmap[pc_lo[3:0]]});
            chk("rnd_disp5", {25'd0, display5}, (final_flag != 0) ? 32'h0E : 32'h7F);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
